// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
//   DefaultWidth : default parallel word width in bits
//   state_e      : serializer FSM states (idle, shifting a word out)
package piso_serializer_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

endpackage

// File: rtl/bit_counter.sv
// Bit-position counter for the serializer.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset (clears count)
//   clr_i  : synchronous clear, takes priority over en_i
//   en_i   : increment enable
//   cnt_o  : current count, $clog2(Width) bits
//   tc_o   : terminal count, high when cnt_o == Width-1
module bit_counter import piso_serializer_pkg::*; #(
  parameter int unsigned Width = DefaultWidth,
  localparam int unsigned CntW = $clog2(Width)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [CntW-1:0] cnt_o,
  output logic            tc_o
);

  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LastCnt);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer, MSB first, with load handshake and stall.
//   CLK        : clock, rising edge
//   RESET      : synchronous active-high reset
//   DATA_PAR   : parallel word to transmit
//   LOAD_VALID : DATA_PAR valid for capture
//   LOAD_READY : word can be accepted this cycle (only output that depends on an input)
//   STALL      : freezes shifting while high
//   DATA_OUT   : serial bit stream
//   BIT_VALID  : DATA_OUT carries a live bit this cycle
//   WORD_DONE  : one-cycle strobe on the last bit of a word
module piso_serializer import piso_serializer_pkg::*; #(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA_PAR,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic             STALL,
  output logic             DATA_OUT,
  output logic             BIT_VALID,
  output logic             WORD_DONE
);

  localparam int unsigned CntW = $clog2(WIDTH);
  // Shifting from this count lands on the last bit of the word.
  localparam logic [CntW-1:0] PenultCnt = CntW'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             bit_valid_q, bit_valid_d;
  logic             word_done_q, word_done_d;

  logic             accept;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic [CntW-1:0]  cnt;

  bit_counter #(
    .Width (WIDTH)
  ) u_bit_counter (
    .clk_i (CLK),
    .rst_i (RESET),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  assign LOAD_READY = (state_q == StIdle) || (cnt_tc && !STALL);
  assign accept     = LOAD_VALID && LOAD_READY;

  // STALL seen at an edge freezes the register and blanks BIT_VALID for the
  // following cycle; the bit shown before that edge was already consumed, so
  // the deferred shift on resume neither drops nor repeats a bit.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_valid_d = 1'b0;
    word_done_d = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d     = StShift;
          shreg_d     = DATA_PAR;
          cnt_clr     = 1'b1;
          bit_valid_d = 1'b1;
        end
      end
      StShift: begin
        if (STALL) begin
          // hold everything, BIT_VALID drops
        end else if (cnt_tc) begin
          cnt_clr = 1'b1;
          if (accept) begin
            shreg_d     = DATA_PAR;
            bit_valid_d = 1'b1;
          end else begin
            state_d = StIdle;
            shreg_d = '0;
          end
        end else begin
          shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_en      = 1'b1;
          bit_valid_d = 1'b1;
          word_done_d = (cnt == PenultCnt);
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bit_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_valid_q <= bit_valid_d;
      word_done_q <= word_done_d;
    end
  end

  assign DATA_OUT  = shreg_q[WIDTH-1];
  assign BIT_VALID = bit_valid_q;
  assign WORD_DONE = word_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed words, expected serial
// bits queued at stimulus time and checked by a monitor on the falling edge.
module tb_piso_serializer;

  typedef struct packed {
    logic d;
    logic done;
  } exp_t;

  logic       clk;
  logic       RESET;
  logic [7:0] DATA_PAR;
  logic       LOAD_VALID, LOAD_READY, STALL;
  logic       DATA_OUT, BIT_VALID, WORD_DONE;

  logic [3:0] d4;
  logic       lv4, st4, rdy4, out4, bv4, wd4;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic mon_en = 1'b0;
  logic [7:0] ds = '0;

  piso_serializer #(.WIDTH(8)) u_dut (
    .CLK        (clk),
    .RESET      (RESET),
    .DATA_PAR   (DATA_PAR),
    .LOAD_VALID (LOAD_VALID),
    .LOAD_READY (LOAD_READY),
    .STALL      (STALL),
    .DATA_OUT   (DATA_OUT),
    .BIT_VALID  (BIT_VALID),
    .WORD_DONE  (WORD_DONE)
  );

  piso_serializer #(.WIDTH(4)) u_dut4 (
    .CLK        (clk),
    .RESET      (RESET),
    .DATA_PAR   (d4),
    .LOAD_VALID (lv4),
    .LOAD_READY (rdy4),
    .STALL      (st4),
    .DATA_OUT   (out4),
    .BIT_VALID  (bv4),
    .WORD_DONE  (wd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w, input int nbits);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      e.d    = w[7-i];
      e.done = (i == 7);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [7:0] w);
    bit ok;
    ok = 1'b0;
    DATA_PAR   = w;
    LOAD_VALID = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (LOAD_READY) ok = 1'b1;
      tick();
    end
    LOAD_VALID = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every live bit must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (BIT_VALID === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bit: got bit %b with empty queue (t=%0t)", DATA_OUT, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("serial_bit", 32'(DATA_OUT), 32'(mon_e.d));
          check("word_done", 32'(WORD_DONE), 32'(mon_e.done));
        end
        ds = {ds[6:0], DATA_OUT};
      end else begin
        check("done_without_valid", 32'(WORD_DONE), 32'd0);
      end
    end
  end

  initial begin : stim
    logic [3:0] w4;
    int cyc;
    bit seen;

    RESET      = 1'b1;
    DATA_PAR   = '0;
    LOAD_VALID = 1'b0;
    STALL      = 1'b0;
    d4         = '0;
    lv4        = 1'b0;
    st4        = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_data_out", 32'(DATA_OUT), 32'd0);
    check("rst_bit_valid", 32'(BIT_VALID), 32'd0);
    check("rst_word_done", 32'(WORD_DONE), 32'd0);
    check("rst_load_ready", 32'(LOAD_READY), 32'd1);
    RESET  = 1'b0;
    mon_en = 1'b1;
    tick();

    // Single word, no stall; downstream register collects it
    push_word(8'b10101101, 8);
    send(8'b10101101);
    wait_drain();
    check("downstream_word", 32'(ds), 32'hAD);
    repeat (2) tick();

    // Back-to-back words, LOAD_VALID held: no gap bit
    push_word(8'hA5, 8);
    push_word(8'h3C, 8);
    send(8'hA5);
    DATA_PAR   = 8'h3C;
    LOAD_VALID = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("b2b_valid", 32'(BIT_VALID), 32'd1);
      if (i == 7) check("b2b_ready_last", 32'(LOAD_READY), 32'd1);
      tick();
      if (i == 7) LOAD_VALID = 1'b0;
    end
    check("idle_valid", 32'(BIT_VALID), 32'd0);
    check("idle_data_out", 32'(DATA_OUT), 32'd0);
    check("idle_ready", 32'(LOAD_READY), 32'd1);
    wait_drain();

    // Stall for 3 cycles after bit 2
    push_word(8'hF0, 8);
    send(8'hF0);
    tick();
    STALL = 1'b1;
    repeat (3) begin
      tick();
      check("stall_valid", 32'(BIT_VALID), 32'd0);
      check("stall_hold", 32'(DATA_OUT), 32'd1);
    end
    STALL = 1'b0;
    cyc  = 5;
    seen = 1'b0;
    while (!seen && cyc < 30) begin
      tick();
      cyc++;
      if (WORD_DONE) seen = 1'b1;
    end
    check("stall_done_cycle", 32'(cyc), 32'd11);
    wait_drain();
    repeat (2) tick();

    // Reset in mid-word after bit 4
    push_word(8'hFF, 4);
    send(8'hFF);
    repeat (3) tick();
    RESET = 1'b1;
    tick();
    check("abort_data_out", 32'(DATA_OUT), 32'd0);
    check("abort_valid", 32'(BIT_VALID), 32'd0);
    check("abort_ready", 32'(LOAD_READY), 32'd1);
    check("abort_done", 32'(WORD_DONE), 32'd0);
    RESET = 1'b0;
    repeat (5) tick();
    check("abort_no_bits", 32'(BIT_VALID), 32'd0);
    wait_drain();

    // Mid-word load pulse is ignored
    push_word(8'h96, 8);
    send(8'h96);
    repeat (2) tick();
    DATA_PAR   = 8'h00;
    LOAD_VALID = 1'b1;
    check("midword_not_ready", 32'(LOAD_READY), 32'd0);
    tick();
    LOAD_VALID = 1'b0;
    wait_drain();
    check("midword_word", 32'(ds), 32'h96);
    repeat (2) tick();

    // WIDTH=4 instance
    w4  = 4'b1001;
    check("w4_ready", 32'(rdy4), 32'd1);
    d4  = w4;
    lv4 = 1'b1;
    tick();
    lv4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("w4_valid", 32'(bv4), 32'd1);
      check("w4_bit", 32'(out4), 32'(w4[3-i]));
      check("w4_done", 32'(wd4), 32'(i == 3));
      tick();
    end
    check("w4_idle", 32'(bv4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The module SHALL take parameter WIDTH, default 8, which sets the parallel word width in bits (legal range 2..32).
REQ-002 The module SHALL have port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port RESET, input, 1 bit: synchronous, active-high reset sampled on the rising edge of CLK.
REQ-004 The module SHALL have port DATA_PAR, input, WIDTH bits: the parallel word to transmit.
REQ-005 The module SHALL have port LOAD_VALID, input, 1 bit: DATA_PAR is valid for capture.
REQ-006 The module SHALL have port LOAD_READY, output, 1 bit: the serializer can accept a word this cycle.
REQ-007 The module SHALL have port STALL, input, 1 bit: freezes shifting while high.
REQ-008 The module SHALL have port DATA_OUT, output, 1 bit: serial bit stream to the downstream shift register DATA_IN.
REQ-009 The module SHALL have port BIT_VALID, output, 1 bit: DATA_OUT carries a live bit this cycle.
REQ-010 The module SHALL have port WORD_DONE, output, 1 bit: one-cycle strobe marking the last bit of a word.

Function
REQ-011 The module SHALL drive every output from a register; no combinational path SHALL run from input to output, except LOAD_READY's dependence on STALL.
REQ-012 The module SHALL implement a two-state FSM, IDLE and SHIFT.
REQ-013 The module SHALL accept a word when LOAD_VALID and LOAD_READY are both high at a rising CLK edge: DATA_PAR is captured into the shift register, the bit counter is cleared, and the state becomes SHIFT.
REQ-014 The module SHALL drive LOAD_READY high in IDLE, and in SHIFT only when the counter equals WIDTH-1 and STALL is low.
REQ-015 The module SHALL ignore LOAD_VALID while LOAD_READY is low; the upstream block SHALL hold DATA_PAR stable until acceptance.
REQ-016 The module SHALL transmit MSB first: in the first SHIFT cycle DATA_OUT = captured[WIDTH-1], and on each non-stalled edge the register shifts left one place and the counter increments.
REQ-017 The module SHALL present the MSB in the cycle after acceptance (latency 1 clock) and the LSB WIDTH cycles after acceptance when no stall occurs.
REQ-018 The module SHALL drive BIT_VALID high in every SHIFT cycle with STALL low; BIT_VALID SHALL be low in IDLE and while stalled.
REQ-019 The module SHALL hold DATA_OUT at its current value while stalled, and SHALL hold the counter and shift register unchanged.
REQ-020 The module SHALL assert WORD_DONE exactly in the cycle where counter = WIDTH-1 and BIT_VALID is high.
REQ-021 Back-to-back: on a non-stalled last-bit edge with acceptance, the module SHALL load the new word and present its MSB on the next cycle with no gap bit.
REQ-022 On a last-bit edge without acceptance, the module SHALL return to IDLE, drive DATA_OUT to 0, and drive BIT_VALID low.
REQ-023 In IDLE, STALL SHALL have no effect.

Reset
REQ-024 With RESET high at an edge, the module SHALL enter IDLE, clear the shift register and counter, and drive DATA_OUT=0, BIT_VALID=0 and WORD_DONE=0; LOAD_READY SHALL read 1 after the edge.
REQ-025 Reset during SHIFT SHALL abort the word with no WORD_DONE; no partial bits SHALL follow reset release.
REQ-026 RESET SHALL take priority over LOAD_VALID and STALL at the same edge.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, SHIFT) and the default WIDTH constant.
REQ-028 The counter SHALL be a sub-module bit_counter, with clear, enable and terminal-count output and width $clog2(WIDTH).

Verification
REQ-029 Reset then load 8'b10101101 with no stall -> DATA_OUT over 8 cycles = 1,0,1,0,1,1,0,1; WORD_DONE high only on the 8th bit; a downstream 8-bit shift register then reads 8'b10101101.
REQ-030 Load 8'hA5 then 8'h3C with LOAD_VALID held -> 16 consecutive BIT_VALID cycles giving 10100101 00111100; WORD_DONE on cycles 8 and 16.
REQ-031 Load 8'hF0 and raise STALL for 3 cycles after bit 2 -> DATA_OUT holds 1 and BIT_VALID=0 for 3 cycles; the sequence resumes and WORD_DONE arrives 11 cycles after acceptance.
REQ-032 Assert RESET after bit 4 of 8'hFF -> the next cycle shows DATA_OUT=0, BIT_VALID=0, LOAD_READY=1; no WORD_DONE occurs.
REQ-033 Pulse LOAD_VALID with 8'h00 in mid-word -> the word is ignored and the current word completes unchanged.
REQ-034 Run with WIDTH=4 and load 4'b1001 -> bits 1,0,0,1; WORD_DONE on the 4th bit.
